reset_sequencer: RTL and testbench

- Parametrised successor to the single-output reset synchroniser.
- Converts the asynchronous board reset into a clk-domain reset, then releases NUM_OUTPUTS reset lines one at a time, RELEASE_GAP cycles apart.
- Supports a synchronous soft-reset request that re-runs the hold and release sequence.
- Sits at the top of each clock domain and feeds the domain's UART, ALU and register-file reset inputs in a fixed order.

---
 rtl/reset_sequencer.sv | 163 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Board reset synchroniser plus ordered release of NUM_OUTPUTS reset lines, with synchronous soft reset.
// Optional RST_SEQ_REVERSE_ASSERT_EN: soft reset asserts outputs in reverse order, RELEASE_GAP apart.
module reset_sequencer #(
    parameter int unsigned NUM_OF_STAGES = 3,
    parameter int unsigned NUM_OUTPUTS   = 4,
    parameter int unsigned RELEASE_GAP   = 8,
    parameter int unsigned SOFT_HOLD     = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   soft_rst_req,
    output logic                   sync_reset_n,
    output logic [NUM_OUTPUTS-1:0] rst_n_out,
    output logic                   rst_done
);

    localparam int unsigned CNT_MAX = (RELEASE_GAP > SOFT_HOLD) ? RELEASE_GAP : SOFT_HOLD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W   = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(RELEASE_GAP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SOFT_HOLD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUTPUTS - 1);

    typedef enum logic [2:0] {
        ST_WAIT_SYNC = 3'd0,
        ST_RELEASE   = 3'd1,
        ST_DONE      = 3'd2,
`ifdef RST_SEQ_REVERSE_ASSERT_EN
        ST_REVERSE   = 3'd4,
`endif
        ST_SOFT_HOLD = 3'd3
    } state_t;

    state_t                 state, state_nxt;
    logic [NUM_OF_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic [NUM_OUTPUTS-1:0] out_nxt;
    logic                   done_nxt;
    logic                   launch;
    logic                   take_soft;

    // Shift-in-ones synchroniser: async assert, sync deassert
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NUM_OF_STAGES-2:0], 1'b1};
        end
    end

    assign sync_reset_n = sync_q[NUM_OF_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_WAIT_SYNC;
            cnt       <= '0;
            idx       <= '0;
            rst_n_out <= '0;
            rst_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            rst_n_out <= out_nxt;
            rst_done  <= done_nxt;
        end
    end

    // Next state; launch starts a release sequence with bit 0, take_soft begins a soft reset
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        out_nxt   = rst_n_out;
        done_nxt  = rst_done;
        launch    = 1'b0;
        take_soft = 1'b0;

        case (state)
            ST_WAIT_SYNC: begin
                launch = sync_reset_n;
            end
            ST_RELEASE: begin
                if (soft_rst_req) begin
                    take_soft = 1'b1;
                end else if (cnt == GAP_LAST) begin
                    out_nxt[idx] = 1'b1;
                    cnt_nxt      = '0;
                    if (idx == IDX_LAST) begin
                        done_nxt  = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                take_soft = soft_rst_req;
            end
            ST_SOFT_HOLD: begin
                if (soft_rst_req) begin
                    cnt_nxt = '0;
                end else if (cnt == HOLD_LAST) begin
                    launch = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
`ifdef RST_SEQ_REVERSE_ASSERT_EN
            // Reverse walk: idx is the most recently asserted bit; requests are ignored here
            ST_REVERSE: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt                   = '0;
                    idx_nxt                   = idx - IDX_W'(1);
                    out_nxt[idx - IDX_W'(1)]  = 1'b0;
                    if (idx == IDX_W'(1)) begin
                        state_nxt = ST_SOFT_HOLD;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
`endif
            default: begin
                state_nxt = ST_WAIT_SYNC;
            end
        endcase

        if (launch) begin
            out_nxt[0] = 1'b1;
            cnt_nxt    = '0;
            if (NUM_OUTPUTS == 1) begin
                done_nxt  = 1'b1;
                state_nxt = ST_DONE;
            end else begin
                idx_nxt   = IDX_W'(1);
                state_nxt = ST_RELEASE;
            end
        end

        if (take_soft) begin
            done_nxt = 1'b0;
            cnt_nxt  = '0;
`ifdef RST_SEQ_REVERSE_ASSERT_EN
            out_nxt[NUM_OUTPUTS-1] = 1'b0;
            idx_nxt                = IDX_LAST;
            if (NUM_OUTPUTS == 1) begin
                state_nxt = ST_SOFT_HOLD;
            end else begin
                state_nxt = ST_REVERSE;
            end
`else
            out_nxt   = '0;
            state_nxt = ST_SOFT_HOLD;
`endif
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default and corner-parameter instances checked every cycle
// against an edge-arithmetic reference model.
module tb_reset_sequencer;

    localparam int unsigned D_STG = 3, D_NO = 4, D_GAP = 8, D_HLD = 16;
    localparam int unsigned C_STG = 2, C_NO = 1, C_GAP = 1, C_HLD = 1;
    localparam int INF = 1 << 28;
`ifdef RST_SEQ_REVERSE_ASSERT_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic            soft_d = 1'b0;
    logic            soft_c = 1'b0;
    logic            sync_d, sync_c, done_d, done_c;
    logic [D_NO-1:0] out_d;
    logic [C_NO-1:0] out_c;

    reset_sequencer #(
        .NUM_OF_STAGES(D_STG), .NUM_OUTPUTS(D_NO), .RELEASE_GAP(D_GAP), .SOFT_HOLD(D_HLD)
    ) u_dut_d (
        .clk(clk), .reset_n(reset_n), .soft_rst_req(soft_d),
        .sync_reset_n(sync_d), .rst_n_out(out_d), .rst_done(done_d)
    );

    reset_sequencer #(
        .NUM_OF_STAGES(C_STG), .NUM_OUTPUTS(C_NO), .RELEASE_GAP(C_GAP), .SOFT_HOLD(C_HLD)
    ) u_dut_c (
        .clk(clk), .reset_n(reset_n), .soft_rst_req(soft_c),
        .sync_reset_n(sync_c), .rst_n_out(out_c), .rst_done(done_c)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Model: each instance is described by edge numbers only
    int stg[2] = '{D_STG, C_STG};
    int no[2]  = '{D_NO, C_NO};
    int gap[2] = '{D_GAP, C_GAP};
    int hld[2] = '{D_HLD, C_HLD};
    int rr[2];     // first edge after reset_n rose
    int base[2];   // edge at which bit 0 rises
    int obase[2];  // previous base, for bits still high during a reverse walk
    int f[2];      // edge a reverse walk started
    bit sft[2];    // a soft reset has been taken since reset

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp_v);
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            rr[k] = INF; base[k] = INF; obase[k] = INF; f[k] = INF; sft[k] = 1'b0;
        end
    endtask

    task automatic model_edge(input int k, input logic req);
        int  e;
        int  walk_end;
        bit  walking, hold, run;
        e = cyc;
        if (reset_n) begin
            if (rr[k] == INF) begin
                rr[k]   = e;
                base[k] = e + stg[k];
            end
            walk_end = (f[k] == INF) ? INF : f[k] + (no[k] - 1) * gap[k];
            walking  = REV && (f[k] != INF) && (e <= walk_end);
            hold     = sft[k] && !walking && (base[k] >= e);
            run      = !walking && !hold && (base[k] <= e - 1);
            if (req) begin
                if (run) begin
                    if (REV) begin
                        obase[k] = base[k];
                        f[k]     = e;
                        base[k]  = e + (no[k] - 1) * gap[k] + hld[k];
                    end else begin
                        base[k] = e + hld[k];
                    end
                    sft[k] = 1'b1;
                end else if (hold) begin
                    base[k] = e + hld[k];
                end
            end
        end
    endtask

    function automatic logic [31:0] exp_out(input int k);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < no[k]; i++) begin
            if (cyc >= base[k] + i * gap[k]) v[i] = 1'b1;
            if (REV && f[k] != INF && obase[k] + i * gap[k] <= f[k] - 1 &&
                cyc < f[k] + (no[k] - 1 - i) * gap[k]) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_done(input int k);
        return 32'(cyc >= base[k] + (no[k] - 1) * gap[k]);
    endfunction

    function automatic logic [31:0] exp_sync(input int k);
        return 32'(rr[k] != INF && cyc >= rr[k] + stg[k] - 1);
    endfunction

    task automatic compare_all(input string ph);
        check({ph, "_d_sync"}, 32'(sync_d), exp_sync(0));
        check({ph, "_d_out"},  32'(out_d),  exp_out(0));
        check({ph, "_d_done"}, 32'(done_d), exp_done(0));
        check({ph, "_c_sync"}, 32'(sync_c), exp_sync(1));
        check({ph, "_c_out"},  32'(out_c),  exp_out(1));
        check({ph, "_c_done"}, 32'(done_c), exp_done(1));
    endtask

    // Drive requests for the coming edge, advance one edge, compare just after it
    task automatic step(input string ph, input logic rq_d, input logic rq_c);
        soft_d = rq_d;
        soft_c = rq_c;
        @(posedge clk);
        cyc++;
        model_edge(0, rq_d);
        model_edge(1, rq_c);
        #1;
        compare_all(ph);
    endtask

    // Mid-cycle asynchronous reset assertion, checked before the next edge
    task automatic drop_reset(input string ph);
        #3;
        reset_n = 1'b0;
        model_clear();
        #1;
        compare_all(ph);
    endtask

    initial begin
        model_clear();
        #1 reset_n = 1'b0;
        #1 compare_all("por");
        repeat (5) step("por_low", 1'b0, 1'b0);
        reset_n = 1'b1;
        repeat (45) step("powerup", 1'b0, 1'b0);

        step("soft", 1'b1, 1'b1);
        repeat (9) step("soft_hold", 1'b0, 1'b0);
        step("soft_ext", 1'b1, 1'b0);
        repeat (70) step("soft_rel", 1'b0, 1'b0);

        // Restart, then assert reset at edge 15 while rst_n_out is partly released
        drop_reset("async0");
        repeat (3) step("rst_low", 1'b0, 1'b0);
        reset_n = 1'b1;
        repeat (15) step("pre_drop", 1'b0, 1'b0);
        drop_reset("async15");
        repeat (2) step("rst_low2", 1'b0, 1'b0);
        reset_n = 1'b1;
        repeat (45) step("restart", 1'b0, 1'b0);

        // Requests held through WAIT_SYNC are ignored
        drop_reset("async_ws");
        repeat (2) step("rst_low3", 1'b0, 1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) step("ws_req", 1'b1, i < 3);
        repeat (40) step("ws_rel", 1'b0, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                drop_reset("rnd_async");
                repeat ($urandom_range(1, 3)) step("rnd_low", 1'b0, 1'b0);
                reset_n = 1'b1;
            end
            step("rnd", $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
